// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - two-master (ibus/dbus) to one-slave bus arbiter with optional watchdog
module cpu_bus_arbiter #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    output logic [31:0] o_dbus_rdata,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic        o_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    state_t        state_next;
    logic          last_d;
    logic [CW-1:0] wd_count;
    logic          granted;
    logic          expire;
    logic          done;
    logic          pick_d;

    always_comb begin
        granted    = (state != IDLE);
        expire     = (TIMEOUT > 0) && granted && !i_bus_ready && (wd_count == WD_LAST);
        done       = granted && (i_bus_ready || expire);
        // On contention the master that did not win last time gets the bus
        pick_d     = i_dbus_request && (!i_ibus_request || !last_d);
        state_next = state;
        case (state)
            IDLE: begin
                if (i_ibus_request || i_dbus_request)
                    state_next = pick_d ? GRANT_D : GRANT_I;
            end
            default: begin
                if (done)
                    state_next = IDLE;
            end
        endcase

        o_ibus_ready = (state == GRANT_I) && done;
        o_dbus_ready = (state == GRANT_D) && done;
        o_ibus_rdata = ((state == GRANT_I) && i_bus_ready) ? i_bus_rdata : 32'h0;
        o_dbus_rdata = ((state == GRANT_D) && i_bus_ready) ? i_bus_rdata : 32'h0;
        o_fault      = expire;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            last_d        <= 1'b1;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= 32'h0;
            o_bus_wdata   <= 32'h0;
            wd_count      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE) begin
                o_bus_request <= 1'b1;
                wd_count      <= '0;
                if (state_next == GRANT_D) begin
                    o_bus_rw      <= i_dbus_rw;
                    o_bus_address <= i_dbus_address;
                    o_bus_wdata   <= i_dbus_wdata;
                end else begin
                    o_bus_rw      <= 1'b0;
                    o_bus_address <= i_ibus_address;
                    o_bus_wdata   <= 32'h0;
                end
            end else if (done) begin
                o_bus_request <= 1'b0;
                last_d        <= (state == GRANT_D);
                wd_count      <= '0;
            end else if (granted) begin
                wd_count <= wd_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

    localparam int TIMEOUT = 8;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_ibus_request = 1'b0;
    logic        o_ibus_ready;
    logic [31:0] i_ibus_address = 32'h0;
    logic [31:0] o_ibus_rdata;
    logic        i_dbus_rw = 1'b0;
    logic        i_dbus_request = 1'b0;
    logic        o_dbus_ready;
    logic [31:0] i_dbus_address = 32'h0;
    logic [31:0] o_dbus_rdata;
    logic [31:0] i_dbus_wdata = 32'h0;
    logic        o_bus_rw;
    logic        o_bus_request;
    logic        i_bus_ready = 1'b0;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata = 32'h0;
    logic [31:0] o_bus_wdata;
    logic        o_fault;

    cpu_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_ibus_request (i_ibus_request),
        .o_ibus_ready   (o_ibus_ready),
        .i_ibus_address (i_ibus_address),
        .o_ibus_rdata   (o_ibus_rdata),
        .i_dbus_rw      (i_dbus_rw),
        .i_dbus_request (i_dbus_request),
        .o_dbus_ready   (o_dbus_ready),
        .i_dbus_address (i_dbus_address),
        .o_dbus_rdata   (o_dbus_rdata),
        .i_dbus_wdata   (i_dbus_wdata),
        .o_bus_rw       (o_bus_rw),
        .o_bus_request  (o_bus_request),
        .i_bus_ready    (i_bus_ready),
        .o_bus_address  (o_bus_address),
        .i_bus_rdata    (i_bus_rdata),
        .o_bus_wdata    (o_bus_wdata),
        .o_fault        (o_fault)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Master-side view: outstanding requests and the fields they hold
    logic        i_pend = 1'b0;
    logic        d_pend = 1'b0;
    logic [31:0] ia_h = 32'h0;
    logic [31:0] da_h = 32'h0;
    logic [31:0] dw_h = 32'h0;
    logic        drw_h = 1'b0;
    int          grant_log[$];

    typedef struct {
        logic        ni;
        logic [31:0] ia;
        logic        nd;
        logic        drw;
        logic [31:0] da;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        int          win;
    } vec_t;

    vec_t tbl [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner from the arbitration rule: sole requester, else the one not served last
    function automatic int model_winner();
        if (i_pend && !d_pend) return 0;
        if (d_pend && !i_pend) return 1;
        if (grant_log.size() == 0) return 0;
        return 1 - grant_log[$];
    endfunction

    task automatic apply_pending();
        i_ibus_request = i_pend;
        i_ibus_address = ia_h;
        i_dbus_request = d_pend;
        i_dbus_address = da_h;
        i_dbus_rw      = drw_h;
        i_dbus_wdata   = dw_h;
    endtask

    task automatic do_txn(input logic ni, input logic [31:0] ia, input logic nd, input logic drw,
                          input logic [31:0] da, input logic [31:0] wd, input int lat,
                          input logic [31:0] rd, input int exp_win);
        int   win;
        logic fin;
        logic rdy_exp;
        logic flt_exp;
        if (ni && !i_pend) begin i_pend = 1'b1; ia_h = ia; end
        if (nd && !d_pend) begin d_pend = 1'b1; da_h = da; drw_h = drw; dw_h = wd; end
        win = (exp_win < 0) ? model_winner() : exp_win;
        @(negedge i_clock);
        apply_pending();
        i_reset     = 1'b1;
        i_bus_ready = 1'b0;
        i_bus_rdata = rd;
        #1;
        chk("idle_bus_request", o_bus_request, 0);
        chk("idle_ibus_ready", o_ibus_ready, 0);
        chk("idle_dbus_ready", o_dbus_ready, 0);
        fin = 1'b0;
        for (int k = 0; k < TIMEOUT + 2 && !fin; k++) begin
            @(negedge i_clock);
            i_bus_ready = (k == lat);
            #1;
            flt_exp = (k == TIMEOUT - 1) && (lat > k);
            rdy_exp = (k == lat) || flt_exp;
            chk("bus_request", o_bus_request, 1);
            chk("bus_address", o_bus_address, win ? da_h : ia_h);
            chk("bus_rw", o_bus_rw, win ? drw_h : 1'b0);
            if (win == 1) chk("bus_wdata", o_bus_wdata, dw_h);
            chk("ibus_ready", o_ibus_ready, (win == 0) && rdy_exp);
            chk("dbus_ready", o_dbus_ready, (win == 1) && rdy_exp);
            chk("ibus_rdata", o_ibus_rdata, (win == 0 && k == lat) ? rd : 32'h0);
            chk("dbus_rdata", o_dbus_rdata, (win == 1 && k == lat) ? rd : 32'h0);
            chk("fault", o_fault, flt_exp);
            if (rdy_exp) fin = 1'b1;
        end
        grant_log.push_back(win);
        if (win == 1) d_pend = 1'b0; else i_pend = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1, 32'h1111_1111, 1};
        tbl[1] = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        32'h0,        1, 32'h0000_0013, 0};
        tbl[2] = '{1'b1, 32'h200,      1'b1, 1'b0, 32'h3000,     32'h0,        1, 32'h0000_00A1, 1};
        tbl[3] = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h3004,     32'h0,        1, 32'h0000_00A2, 0};
        tbl[4] = '{1'b1, 32'h204,      1'b1, 1'b0, 32'h0,        32'h0,        1, 32'h0000_00A3, 1};
        tbl[5] = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h3008,     32'h0,        1, 32'h0000_00A4, 0};
        tbl[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        0, 32'h0000_0055, 1};
        tbl[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 2, 32'h0,        1};
        tbl[8] = '{1'b1, 32'h104,      1'b0, 1'b0, 32'h0,        32'h0,        3, 32'h0000_0077, 0};

        // Reset held with both masters requesting and a stray slave ready
        i_pend = 1'b1; ia_h = 32'h400;
        d_pend = 1'b1; da_h = 32'h500; drw_h = 1'b0; dw_h = 32'h0;
        apply_pending();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge i_clock);
        #1;
        chk("rst_bus_request", o_bus_request, 0);
        chk("rst_bus_rw", o_bus_rw, 0);
        chk("rst_bus_address", o_bus_address, 0);
        chk("rst_bus_wdata", o_bus_wdata, 0);
        chk("rst_ibus_ready", o_ibus_ready, 0);
        chk("rst_dbus_ready", o_dbus_ready, 0);
        chk("rst_ibus_rdata", o_ibus_rdata, 0);
        chk("rst_dbus_rdata", o_dbus_rdata, 0);
        chk("rst_fault", o_fault, 0);
        do_txn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0BAD_F00D, 0);

        for (int v = 0; v <= 8; v++)
            do_txn(tbl[v].ni, tbl[v].ia, tbl[v].nd, tbl[v].drw, tbl[v].da, tbl[v].wd,
                   tbl[v].lat, tbl[v].rd, tbl[v].win);

        for (int r = 0; r < 40; r++) begin
            logic ni, nd;
            ni = (!i_pend) && ($urandom_range(0, 1) == 1);
            nd = (!d_pend) && ($urandom_range(0, 1) == 1);
            if (!i_pend && !d_pend && !ni && !nd) ni = 1'b1;
            do_txn(ni, $urandom, nd, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, 5)), $urandom, -1);
        end
        while (i_pend || d_pend)
            do_txn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, $urandom, -1);

        // Watchdog: slave never answers
        do_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1000, 32'hBAD0_BAD0, 1);
        @(negedge i_clock);
        apply_pending();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h1234;
        #1;
        chk("late_ready_ibus", o_ibus_ready, 0);
        chk("late_ready_dbus", o_dbus_ready, 0);
        chk("late_ready_drdata", o_dbus_rdata, 0);
        chk("late_ready_fault", o_fault, 0);
        chk("late_ready_busreq", o_bus_request, 0);
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        #1;
        chk("after_wd_busreq", o_bus_request, 0);

        // Reset while a dbus write is granted
        d_pend = 1'b1; da_h = 32'h600; drw_h = 1'b1; dw_h = 32'hCAFE;
        @(negedge i_clock);
        apply_pending();
        @(negedge i_clock);
        #1;
        chk("midrst_grant_req", o_bus_request, 1);
        chk("midrst_grant_addr", o_bus_address, 32'h600);
        i_reset = 1'b0;
        #1;
        chk("midrst_busreq_drop", o_bus_request, 0);
        i_bus_ready = 1'b1;
        #1;
        chk("midrst_dbus_ready", o_dbus_ready, 0);
        chk("midrst_ibus_ready", o_ibus_ready, 0);
        @(negedge i_clock);
        #1;
        chk("midrst_held_req", o_bus_request, 0);
        grant_log.delete();
        i_pend = 1'b1; ia_h = 32'h700;
        d_pend = 1'b1; da_h = 32'h800; drw_h = 1'b0; dw_h = 32'h0;
        do_txn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0000_0700, 0);
        do_txn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0800, 1);

        @(negedge i_clock);
        apply_pending();
        i_bus_ready = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
